// File: rtl/cgra_tile_dma.sv
// cgra_tile_dma: DMA initiator for the external port of the row-banked CGRA tile memory.
//   LOAD  : s_valid/s_ready word stream -> ext_write into one bank.
//   STORE : ext_read/ext_valid -> small read-data FIFO -> m_valid/m_ready stream.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cfg_start/dir/bank/addr/len       transfer setup, sampled in IDLE only
//   cfg_interleave                    bank interleave request (CGRA_DMA_INTERLEAVE_EN builds)
//   cfg_abort                         drop the current transfer, no done pulse
//   busy, done                        status; done is a one-cycle completion pulse
//   s_valid/s_ready/s_data            LOAD input stream
//   m_valid/m_ready/m_data/m_last     STORE output stream
//   ext_addr/bank_sel/read/write/wdata, ext_rdata/ext_valid   tile memory port
// Optional feature macro: CGRA_DMA_INTERLEAVE_EN (word i -> bank (cfg_bank+i)%4, addr steps on bank wrap).
module cgra_tile_dma #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = 13,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_dir,
  input  logic [1:0]            cfg_bank,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_interleave,
  input  logic                  cfg_abort,
  output logic                  busy,
  output logic                  done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [ADDR_WIDTH-1:0] ext_addr,
  output logic [1:0]            ext_bank_sel,
  output logic                  ext_read,
  output logic                  ext_write,
  output logic [DATA_WIDTH-1:0] ext_wdata,
  input  logic [DATA_WIDTH-1:0] ext_rdata,
  input  logic                  ext_valid
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len, r_issued, r_pop_cnt, w_pop_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt, r_ext_addr;
  logic [1:0]            r_bank, w_bank_nxt, r_ext_bank;
  logic                  r_busy, r_done, r_s_ready, r_m_valid, r_m_last;
  logic                  r_ext_read, r_ext_write, r_wr_last;
  logic [DATA_WIDTH-1:0] r_ext_wdata, r_m_data, w_head_nxt;
  logic [CW-1:0]         r_fifo_cnt, r_inflight, w_cnt_nxt;
  logic [CW:0]           w_occ;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  w_accept, w_issue, w_push, w_pop, w_ilv;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef CGRA_DMA_INTERLEAVE_EN
  logic r_ilv;
  // Interleave mode is latched per transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_ilv <= 1'b0;
    else if (r_state == S_IDLE && cfg_start) r_ilv <= cfg_interleave;
  end
  assign w_ilv = r_ilv;
`else
  logic w_unused_ilv;
  assign w_unused_ilv = cfg_interleave;
  assign w_ilv        = 1'b0;
`endif

  // Address sequencing: linear, or bank-first with address step on bank wrap
  always_comb begin
    w_bank_nxt = w_ilv ? r_bank + 2'd1 : r_bank;
    w_addr_nxt = (!w_ilv || r_bank == 2'd3) ? r_addr + ADDR_WIDTH'(1) : r_addr;
  end

  // Next state, handshakes and FIFO bookkeeping
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = (r_state == S_LOAD) && r_s_ready && s_valid;
    w_occ         = (CW+1)'(r_fifo_cnt) + (CW+1)'(r_inflight);
    w_issue       = (r_state == S_STORE) && (r_issued < r_len) && (w_occ < (CW+1)'(FIFO_DEPTH));
    w_push        = (r_state == S_STORE) && ext_valid && (r_inflight != '0);
    w_pop         = r_m_valid && m_ready;
    w_cnt_nxt     = r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    w_rd_ptr_nxt  = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
    w_pop_cnt_nxt = r_pop_cnt + LEN_WIDTH'(w_pop);
    // Head comes straight from ext_rdata when the pushed word is the only one left
    if (w_cnt_nxt == '0)
      w_head_nxt = '0;
    else if (r_fifo_cnt == '0 || (r_fifo_cnt == CW'(1) && w_pop))
      w_head_nxt = ext_rdata;
    else
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    case (r_state)
      S_IDLE:  if (cfg_start) w_state_nxt = (cfg_len == '0) ? S_DONE : (cfg_dir ? S_STORE : S_LOAD);
      S_LOAD:  if (cfg_abort) w_state_nxt = S_IDLE;
               else if (r_ext_write && r_wr_last) w_state_nxt = S_DONE;
      S_STORE: if (cfg_abort) w_state_nxt = S_IDLE;
               else if (w_pop && r_pop_cnt == r_len - LEN_WIDTH'(1)) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; pointers and count live in the control register block
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= ext_rdata;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;   r_len <= '0;       r_issued <= '0;    r_pop_cnt <= '0;
      r_addr <= '0;        r_bank <= '0;      r_busy <= 1'b0;    r_done <= 1'b0;
      r_s_ready <= 1'b0;   r_m_valid <= 1'b0; r_m_last <= 1'b0;  r_m_data <= '0;
      r_ext_read <= 1'b0;  r_ext_write <= 1'b0; r_wr_last <= 1'b0;
      r_ext_addr <= '0;    r_ext_bank <= '0;  r_ext_wdata <= '0;
      r_fifo_cnt <= '0;    r_inflight <= '0;  r_wr_ptr <= '0;    r_rd_ptr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      r_ext_read  <= 1'b0;
      r_ext_write <= 1'b0;
      if (r_state == S_IDLE) begin
        if (cfg_start) begin
          r_len     <= cfg_len;
          r_addr    <= cfg_addr;
          r_bank    <= cfg_bank;
          r_issued  <= '0;
          r_pop_cnt <= '0;
          r_wr_last <= 1'b0;
          r_s_ready <= !cfg_dir && (cfg_len != '0);
        end
      end else if (cfg_abort) begin
        // Flush; a read already in flight returns with inflight==0 and is ignored
        r_s_ready  <= 1'b0;
        r_m_valid  <= 1'b0;
        r_m_last   <= 1'b0;
        r_m_data   <= '0;
        r_fifo_cnt <= '0;
        r_inflight <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_accept) begin
          r_ext_write <= 1'b1;
          r_ext_addr  <= r_addr;
          r_ext_bank  <= r_bank;
          r_ext_wdata <= s_data;
          r_addr      <= w_addr_nxt;
          r_bank      <= w_bank_nxt;
          r_issued    <= r_issued + LEN_WIDTH'(1);
          if (r_issued == r_len - LEN_WIDTH'(1)) begin
            r_s_ready <= 1'b0;
            r_wr_last <= 1'b1;
          end
        end
        if (w_issue) begin
          r_ext_read <= 1'b1;
          r_ext_addr <= r_addr;
          r_ext_bank <= r_bank;
          r_addr     <= w_addr_nxt;
          r_bank     <= w_bank_nxt;
          r_issued   <= r_issued + LEN_WIDTH'(1);
        end
        r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
        r_fifo_cnt <= w_cnt_nxt;
        r_rd_ptr   <= w_rd_ptr_nxt;
        if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
        r_pop_cnt  <= w_pop_cnt_nxt;
        r_m_valid  <= (w_cnt_nxt != '0);
        r_m_data   <= w_head_nxt;
        r_m_last   <= (w_cnt_nxt != '0) && (w_pop_cnt_nxt == r_len - LEN_WIDTH'(1));
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign s_ready      = r_s_ready;
  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign m_last       = r_m_last;
  assign ext_addr     = r_ext_addr;
  assign ext_bank_sel = r_ext_bank;
  assign ext_read     = r_ext_read;
  assign ext_write    = r_ext_write;
  assign ext_wdata    = r_ext_wdata;
endmodule

// File: tb/tb_cgra_tile_dma.sv
// Directed bench for cgra_tile_dma: LOAD/STORE transfers, address wrap, zero length,
// abort/restart, start+abort priority, async reset, and interleave when the macro is set.
module tb_cgra_tile_dma;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned LW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start, cfg_dir, cfg_interleave, cfg_abort;
  logic [1:0]    cfg_bank;
  logic [AW-1:0] cfg_addr;
  logic [LW-1:0] cfg_len;
  logic          busy, done, s_valid, s_ready, m_valid, m_ready, m_last;
  logic          ext_read, ext_write, ext_valid;
  logic [DW-1:0] s_data, m_data, ext_wdata, ext_rdata;
  logic [AW-1:0] ext_addr;
  logic [1:0]    ext_bank_sel;
  logic          pend_v;
  logic [DW-1:0] pend_d;
  logic [AW-1:0] la;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  cgra_tile_dma dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr),
    .cfg_len(cfg_len), .cfg_interleave(cfg_interleave), .cfg_abort(cfg_abort),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ext_addr(ext_addr), .ext_bank_sel(ext_bank_sel), .ext_read(ext_read),
    .ext_write(ext_write), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_valid(ext_valid)
  );

  always #5 clk = ~clk;

  // Memory model: mem[bank][a] = a, returned one cycle after the read strobe
  initial begin
    ext_valid = 1'b0; ext_rdata = '0; pend_v = 1'b0; pend_d = '0;
    forever begin
      @(posedge clk); #1;
      ext_valid = pend_v;
      ext_rdata = pend_d;
      pend_v    = ext_read;
      pend_d    = DW'(ext_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
    cyc++;
  endtask

  task automatic do_load(input int bank, input int addr, input int len, input int ilv,
                         input int base, output logic [AW-1:0] last_addr);
    int sent = 0, nw = 0, first_wr = -1, last_wr = -1, done_cyc = -1, start_cyc;
    logic [AW-1:0] ea;
    logic [1:0]    eb;
    last_addr = '0;
    cfg_start = 1'b1; cfg_dir = 1'b0; cfg_bank = 2'(bank); cfg_addr = AW'(addr);
    cfg_len = LW'(len); cfg_interleave = ilv[0];
    start_cyc = cyc;
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    for (int t = 0; t < 100 && done_cyc < 0; t++) begin
      if (ext_write) begin
        eb = (ilv != 0) ? 2'(bank + nw) : 2'(bank);
        ea = (ilv != 0) ? AW'(addr + (nw >> 2)) : AW'(addr + nw);
        chk($sformatf("load_w%0d_addr", nw), 64'(ext_addr), 64'(ea));
        chk($sformatf("load_w%0d_bank", nw), 64'(ext_bank_sel), 64'(eb));
        chk($sformatf("load_w%0d_data", nw), 64'(ext_wdata), 64'(DW'(base + nw)));
        if (first_wr < 0) first_wr = cyc;
        last_wr   = cyc;
        last_addr = ext_addr;
        nw++;
      end
      if (done) done_cyc = cyc;
      else begin
        s_valid = (sent < len);
        s_data  = DW'(base + sent);
        if (s_valid && s_ready) sent++;
        tick();
      end
    end
    s_valid = 1'b0;
    chk("load_done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("load_nwrites", 64'(nw), 64'(len));
    if (len == 0) chk("load_len0_done_lat", 64'(done_cyc - start_cyc), 64'd1);
    else begin
      chk("load_b2b", 64'(last_wr - first_wr), 64'(len - 1));
      chk("load_done_lat", 64'(done_cyc - last_wr), 64'd1);
    end
    tick();
    chk("load_idle_after", 64'({busy, done, s_ready}), 64'd0);
  endtask

  task automatic do_store(input int bank, input int addr, input int len, input int rmode,
                          input int abort_after);
    int reads = 0, pops = 0, max_out = 0, first_pop = -1, last_pop = -1, done_cyc = -1;
    logic aborted = 1'b0, bank_err = 1'b0, seen = 1'b0;
    cfg_start = 1'b1; cfg_dir = 1'b1; cfg_bank = 2'(bank); cfg_addr = AW'(addr);
    cfg_len = LW'(len); cfg_interleave = 1'b0;
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    for (int t = 0; t < 200 && done_cyc < 0 && !aborted; t++) begin
      if (ext_read) begin
        reads++;
        if (ext_bank_sel != 2'(bank)) bank_err = 1'b1;
        if (reads - pops > max_out) max_out = reads - pops;
      end
      if (done) done_cyc = cyc;
      else if (abort_after != 0 && pops == abort_after) begin
        cfg_abort = 1'b1; m_ready = 1'b0;
        tick();
        cfg_abort = 1'b0; aborted = 1'b1;
      end else begin
        m_ready = (rmode == 0) || (t % 3 == 0);
        if (m_valid && m_ready) begin
          chk($sformatf("store_w%0d_data", pops), 64'(m_data), 64'(DW'(AW'(addr + pops))));
          chk($sformatf("store_w%0d_last", pops), 64'(m_last), 64'(pops == len - 1));
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
        end
        tick();
      end
    end
    m_ready = 1'b0;
    chk("store_rd_bank_err", 64'(bank_err), 64'd0);
    chk("store_outstanding_le4", 64'(max_out <= 4), 64'd1);
    if (aborted) begin
      chk("abort_pops", 64'(pops), 64'(abort_after));
      chk("abort_idle", 64'({busy, done, m_valid}), 64'd0);
      repeat (6) begin
        tick();
        if (done || m_valid || busy) seen = 1'b1;
      end
      chk("abort_quiet", 64'(seen), 64'd0);
    end else begin
      chk("store_done_seen", 64'(done_cyc >= 0), 64'd1);
      chk("store_npops", 64'(pops), 64'(len));
      if (rmode == 0) chk("store_rate", 64'(last_pop - first_pop), 64'(len - 1));
      chk("store_done_lat", 64'(done_cyc - last_pop), 64'd1);
      tick();
      chk("store_idle_after", 64'({busy, done, m_valid}), 64'd0);
    end
  endtask

  initial begin
    cfg_start = 1'b0; cfg_dir = 1'b0; cfg_interleave = 1'b0; cfg_abort = 1'b0;
    cfg_bank = '0; cfg_addr = '0; cfg_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #23;
    chk("reset_ctl", 64'({busy, done, s_ready, m_valid, m_last, ext_read, ext_write, ext_bank_sel, ext_addr}), 64'd0);
    chk("reset_data", 64'({ext_wdata, m_data}), 64'd0);
    rst_n = 1'b1;
    tick();

    do_load(2, 'h010, 4, 0, 'hA0, la);
    chk("load1_last_addr", 64'(la), 64'h013);
    do_store(1, 'h000, 8, 0, 0);
    do_store(1, 'h000, 8, 1, 0);
    do_load(0, 'hFFE, 3, 0, 'h5000, la);
    chk("wrap_last_addr", 64'(la), 64'h000);
    do_load(3, 'h100, 0, 0, 'h0, la);
    do_store(0, 'h100, 8, 0, 3);
    do_store(0, 'h200, 2, 0, 0);

    // Start and abort together in IDLE: the transfer must still run to completion
    cfg_abort = 1'b1;
    do_load(1, 'h040, 2, 0, 'h77, la);

    // Async reset mid-LOAD
    cfg_start = 1'b1; cfg_dir = 1'b0; cfg_bank = 2'd1; cfg_addr = 12'h300; cfg_len = LW'(4);
    tick();
    cfg_start = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD;
    tick();
    s_valid = 1'b0;
    chk("arst_pre_write", 64'(ext_write), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("arst_outs", 64'({busy, s_ready, ext_write, ext_bank_sel, ext_addr}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_after", 64'({busy, done, ext_write}), 64'd0);
    do_load(1, 'h300, 1, 0, 'h11, la);

`ifdef CGRA_DMA_INTERLEAVE_EN
    do_load(0, 'h020, 6, 1, 'hC0, la);
    chk("ilv_last_addr", 64'(la), 64'h021);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
